// File: rtl/ham_pkg.sv
// ---------------------------------------------------------------------------
// ham_pkg
//   Shared types and constants for the Hamming(7,4) receive path.
//   The serial front end (ham_rx_deser) and the downstream syndrome /
//   correction decoder both import this package so that the codeword width
//   and codeword type stay in one place.
//
//   Contents:
//     CODE_W     - codeword width (7)
//     DATA_W     - payload width carried by one codeword (4)
//     SYN_W      - syndrome width (3)
//     rx_state_t - receive FSM state encoding
//     code_t     - one codeword
//     flip_bit() - invert a single bit of a codeword (pos >= CODE_W: no flip)
// ---------------------------------------------------------------------------
package ham_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    typedef logic [CODE_W-1:0] code_t;

    // Invert bit 'pos' of 'word'. Positions at or beyond CODE_W leave the
    // word untouched, which gives the 3-bit position code a "no flip" value.
    function automatic code_t flip_bit(input code_t word, input logic [2:0] pos);
        code_t result;
        result = word;
        for (int i = 0; i < CODE_W; i++) begin
            if (pos == 3'(i)) begin
                result[i] = ~word[i];
            end
        end
        return result;
    endfunction

endpackage : ham_pkg

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchronizer for a single asynchronous level input.
//   Reusable for switch / button inputs as well as serial lines. The reset
//   value is a parameter so that idle-high lines come out of reset looking
//   idle instead of presenting a false edge.
//
//   Parameters:
//     STAGES    - number of flops in the chain (>= 2)
//     RESET_VAL - value loaded into every flop during reset
//
//   Ports:
//     clk   in  1  destination clock, rising edge
//     rst_n in  1  asynchronous active-low reset
//     d     in  1  asynchronous input
//     q     out 1  synchronized output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Stage 0 takes the raw input; each later stage takes its predecessor.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = d;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/ham_rx_deser.sv
// ---------------------------------------------------------------------------
// ham_rx_deser
//   Serial-to-parallel front end for the Hamming stage. Receives one 7-bit
//   codeword per UART-style frame (1 start bit, 7 code bits LSB first,
//   1 stop bit) and hands it to the downstream decoder over a valid/ready
//   handshake. Flags framing errors (one-cycle pulse) and overruns (sticky).
//
//   Optional build macro:
//     HAM_ERR_INJECT_EN - adds inj_en / inj_pos; on delivery, when inj_en is
//                         high and inj_pos < 7, bit inj_pos of the delivered
//                         codeword is inverted (single-bit error injection for
//                         exercising the corrector). Undefined: ports absent,
//                         codeword delivered exactly as received.
//
//   Parameters:
//     CLKS_PER_BIT - clock cycles per serial bit period (>= 4, even)
//     SYNC_STAGES  - flops in the rx_bit synchronizer (>= 2)
//
//   Ports:
//     clk        in  1  system clock, rising edge
//     rst_n      in  1  asynchronous active-low reset
//     rx_bit     in  1  serial line, idles high, asynchronous to clk
//     code       out 7  captured codeword, code[0] = first data bit received
//     code_valid out 1  code holds an unconsumed codeword
//     code_ready in  1  downstream accepts code when code_valid && code_ready
//     frame_err  out 1  one-cycle pulse: stop bit sampled low
//     overrun    out 1  sticky: good frame completed while previous pending
//     clr_ovr    in  1  synchronous clear of overrun (a new overrun wins)
//     inj_en     in  1  (HAM_ERR_INJECT_EN only) enable error injection
//     inj_pos    in  3  (HAM_ERR_INJECT_EN only) bit to invert, 7 = none
// ---------------------------------------------------------------------------
module ham_rx_deser
    import ham_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_bit,
    output code_t       code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        frame_err,
    output logic        overrun,
    input  logic        clr_ovr
`ifdef HAM_ERR_INJECT_EN
    ,
    input  logic        inj_en,
    input  logic [2:0]  inj_pos
`endif
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        IDX_LAST = 3'(CODE_W - 1);

    // -----------------------------------------------------------------------
    // Input synchronizer: resets to 1 so the idle-high line does not look
    // like a start edge while the chain refills after reset.
    // -----------------------------------------------------------------------
    logic rx_s;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_bit),
        .q     (rx_s)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    rx_state_t         state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [2:0]        idx_q,        idx_d;
    code_t             shift_q,      shift_d;
    code_t             code_q,       code_d;
    logic              code_valid_q, code_valid_d;
    logic              frame_err_q,  frame_err_d;
    logic              overrun_q,    overrun_d;

    // Combinational helpers
    logic              deliver;       // good stop bit sampled this cycle
    logic              consume;       // downstream takes the current word
    logic              slot_free;     // output register may be loaded now
    code_t             deliver_word;  // word that would be loaded on deliver

    assign consume   = code_valid_q && code_ready;
    // A consume in the same cycle frees the slot for the new word, so a
    // back-to-back deliver keeps code_valid high with no overrun.
    assign slot_free = !code_valid_q || code_ready;

    // -----------------------------------------------------------------------
    // Word presented on deliver (optionally with one bit inverted)
    // -----------------------------------------------------------------------
`ifdef HAM_ERR_INJECT_EN
    always_comb begin
        deliver_word = shift_q;
        if (inj_en) begin
            // flip_bit leaves the word alone for inj_pos == 7
            deliver_word = flip_bit(shift_q, inj_pos);
        end
    end
`else
    assign deliver_word = shift_q;
`endif

    // -----------------------------------------------------------------------
    // Receive FSM: next state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                // Check the start bit at its middle. Ending START on the
                // half period puts every later sample point mid-bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;   // too short: glitch, ignored
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RECOVER: begin
                // A held-low line (break) must not be read as a new start
                // bit; wait for the line to return to idle first.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register, handshake and overrun
    // -----------------------------------------------------------------------
    always_comb begin
        code_d       = code_q;
        code_valid_d = code_valid_q;
        overrun_d    = overrun_q;

        if (consume) begin
            code_valid_d = 1'b0;
        end

        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        if (deliver) begin
            if (slot_free) begin
                code_d       = deliver_word;
                code_valid_d = 1'b1;
            end else begin
                // Pending word is kept; the new one is dropped. Set has
                // priority over a simultaneous clear.
                overrun_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule : ham_rx_deser

// File: tb/tb_ham_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_ham_rx_deser
//   Directed bench for ham_rx_deser with CLKS_PER_BIT=4, SYNC_STAGES=2.
//   Frames are driven bit by bit on rx_bit; a monitor records every accepted
//   codeword (code_valid && code_ready) and counts frame_err pulses. Expected
//   codewords are the hand-written constants sent in each frame.
//   Build with +define+HAM_ERR_INJECT_EN to include the injection tests.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ham_rx_deser;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       rx_bit;
    logic [6:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_ovr;
`ifdef HAM_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] got_q[$];
    int         ferr_cnt = 0;

    ham_rx_deser #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
`ifdef HAM_ERR_INJECT_EN
        ,
        .inj_en     (inj_en),
        .inj_pos    (inj_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid && code_ready) got_q.push_back(code);
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s obs=%0h", tag, obs);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_bit = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Leaves rx_bit at the stop-bit value on return.
    task automatic send_frame(input logic [6:0] w, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(w[i]);
        drive_bit(stop);
    endtask

    task automatic pop_check(input string tag, input logic [6:0] exp);
        logic [6:0] v;
        check({tag, "_avail"}, 32'(got_q.size() > 0), 1);
        if (got_q.size() > 0) begin
            v = got_q.pop_front();
            check(tag, 32'(v), 32'(exp));
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!code_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait_valid"}, 32'(n < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ferr0;

        rst_n      = 1'b0;
        rx_bit     = 1'b1;
        code_ready = 1'b0;
        clr_ovr    = 1'b0;
`ifdef HAM_ERR_INJECT_EN
        inj_en     = 1'b0;
        inj_pos    = 3'd7;
`endif
        idle(3);
        check("rst_code",       32'(code),       0);
        check("rst_code_valid", 32'(code_valid), 0);
        check("rst_frame_err",  32'(frame_err),  0);
        check("rst_overrun",    32'(overrun),    0);
        rst_n = 1'b1;
        idle(5);

        // ---- 1: single frame, ready held high
        code_ready = 1'b1;
        send_frame(7'h55, 1'b1);
        idle(8);
        pop_check("t1_code", 7'h55);
        check("t1_one_pulse",  32'(got_q.size()), 0);
        check("t1_valid_low",  32'(code_valid),   0);
        check("t1_frame_err",  32'(ferr_cnt),     0);
        check("t1_overrun",    32'(overrun),      0);

        // ---- 2: overrun while a word is pending, then clear
        code_ready = 1'b0;
        send_frame(7'h4B, 1'b1);
        idle(8);
        check("t2_valid",      32'(code_valid), 1);
        check("t2_code",       32'(code),       32'h4B);
        check("t2_no_ovr",     32'(overrun),    0);
        send_frame(7'h12, 1'b1);
        idle(8);
        check("t2_code_kept",  32'(code),       32'h4B);
        check("t2_ovr_set",    32'(overrun),    1);
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        check("t2_ovr_clr",    32'(overrun),    0);
        code_ready = 1'b1;
        idle(1);
        pop_check("t2_consume", 7'h4B);
        check("t2_valid_drop", 32'(code_valid), 0);

        // ---- 3: framing error, line held low (break), then recovery
        ferr0 = ferr_cnt;
        send_frame(7'h5A, 1'b0);
        idle(3 * CPB);
        check("t3_ferr_once",  32'(ferr_cnt - ferr0), 1);
        check("t3_no_word",    32'(got_q.size()),     0);
        check("t3_no_valid",   32'(code_valid),       0);
        rx_bit = 1'b1;
        idle(8);
        check("t3_ferr_quiet", 32'(ferr_cnt - ferr0), 1);
        send_frame(7'h33, 1'b1);
        idle(8);
        pop_check("t3_next", 7'h33);
        check("t3_ferr_total", 32'(ferr_cnt - ferr0), 1);
        check("t3_one_word",   32'(got_q.size()),     0);

        // ---- 4: 1-clk glitch, then back-to-back frames with toggled ready
        ferr0 = ferr_cnt;
        rx_bit = 1'b0;
        idle(1);
        rx_bit = 1'b1;
        idle(16);
        check("t4_glitch_valid", 32'(code_valid),       0);
        check("t4_glitch_ferr",  32'(ferr_cnt - ferr0), 0);
        check("t4_glitch_word",  32'(got_q.size()),     0);
        code_ready = 1'b0;
        fork
            begin
                send_frame(7'h01, 1'b1);
                send_frame(7'h7F, 1'b1);
                idle(8);
            end
            begin
                repeat (2) begin
                    wait_valid("t4");
                    @(posedge clk); #1;
                    code_ready = 1'b1;
                    @(posedge clk); #1;
                    code_ready = 1'b0;
                end
            end
        join
        idle(4);
        pop_check("t4_first",  7'h01);
        pop_check("t4_second", 7'h7F);
        check("t4_overrun",  32'(overrun),          0);
        check("t4_ferr",     32'(ferr_cnt - ferr0), 0);

        // ---- 5: reset mid-frame (data bit 3) with a word pending
        code_ready = 1'b0;
        send_frame(7'h15, 1'b1);
        idle(8);
        check("t5_pending", 32'(code_valid), 1);
        fork
            send_frame(7'h6C, 1'b1);
            begin
                repeat (18) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check("t5_rst_code",       32'(code),       0);
                check("t5_rst_code_valid", 32'(code_valid), 0);
                check("t5_rst_frame_err",  32'(frame_err),  0);
                check("t5_rst_overrun",    32'(overrun),    0);
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
        join
        // Let any frame started from the aborted tail finish and drain it.
        code_ready = 1'b1;
        idle(80);
        got_q.delete();
        send_frame(7'h2A, 1'b1);
        idle(8);
        pop_check("t5_after_rst", 7'h2A);

`ifdef HAM_ERR_INJECT_EN
        // ---- 6: error injection
        inj_en  = 1'b1;
        inj_pos = 3'd5;
        send_frame(7'h00, 1'b1);
        idle(8);
        pop_check("t6_inj5", 7'h20);
        inj_pos = 3'd7;
        send_frame(7'h00, 1'b1);
        idle(8);
        pop_check("t6_inj7", 7'h00);
        inj_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ham_rx_deser
